// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and helpers for the UART receive buffer.
//   UART_DATA_W : receiver parallel byte width
//   UART_RXF_AW : log2 of the receive FIFO depth
//   OVR_CNT_W   : width of the saturating dropped-byte counter
package uart_rx_fifo_pkg;

   localparam int UART_DATA_W = 8;
   localparam int UART_RXF_AW = 4;
   localparam int OVR_CNT_W   = 8;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
      return (v == {OVR_CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO, shared by the RX and TX paths.
// Ports:
//   clk_i      in   clock
//   rst_i      in   synchronous active-high reset (pointers only, storage not reset)
//   wr_en_i    in   write request; accepted when not full, or when a read frees a slot
//   wr_data_i  in   write data
//   rd_en_i    in   read request; ignored while empty
//   rd_data_o  out  head entry (combinational from registered array), 0 while empty
//   count_o    out  entries held, 0..2**ADDR_W
//   full_o     out  count == 2**ADDR_W
//   empty_o    out  count == 0
module uart_sync_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int ADDR_W = UART_RXF_AW
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_en_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic [ADDR_W:0]   count_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
   logic              rd_ok;
   logic              wr_ok;

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                    (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;

   assign rd_ok = rd_en_i & ~empty_o;
   // A read in the same cycle frees the slot, so a write while full is still taken.
   assign wr_ok = wr_en_i & (~full_o | rd_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_ok && !rst_i) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
   end

   // Gated so the head reads 0 while empty, independent of stale storage.
   assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: detects byte completion on the rising edge of rx_bits_ok_i,
// captures rx_data_i into a FWFT FIFO and presents it on a valid/ready interface.
// Bytes arriving while the FIFO is full (and not being drained that cycle) are
// dropped and recorded in a sticky overrun flag and a saturating counter.
// Ports:
//   sys_clk       in   clock
//   rst           in   synchronous active-high reset
//   rx_data_i     in   receiver parallel byte, sampled on the rx_bits_ok_i rising edge
//   rx_bits_ok_i  in   receiver STOP/IDLE level; 0->1 marks byte complete
//   m_data        out  head byte, 0 while m_valid=0
//   m_valid       out  FIFO non-empty
//   m_ready       in   consumer accepts m_data this cycle
//   count         out  entries held
//   full / empty  out  occupancy flags
//   overrun       out  sticky dropped-byte flag
//   ovr_cnt       out  saturating dropped-byte count
//   ovr_clr       in   clears overrun and ovr_cnt; a same-cycle overrun wins
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int ADDR_W = UART_RXF_AW
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic [DATA_W-1:0]    rx_data_i,
   input  logic                 rx_bits_ok_i,
   output logic [DATA_W-1:0]    m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [ADDR_W:0]      count,
   output logic                 full,
   output logic                 empty,
   output logic                 overrun,
   output logic [OVR_CNT_W-1:0] ovr_cnt,
   input  logic                 ovr_clr
);

   logic                 bits_ok_q;
   logic                 push;
   logic                 pop;
   logic                 ovr_ev;
   logic                 overrun_q, overrun_d;
   logic [OVR_CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;

   // bits_ok_q resets high so a receiver idling at 1 does not look like an edge.
   assign push   = rx_bits_ok_i & ~bits_ok_q;
   assign pop    = m_valid & m_ready;
   assign ovr_ev = push & full & ~pop;

   uart_sync_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk_i     (sys_clk),
      .rst_i     (rst),
      .wr_en_i   (push),
      .wr_data_i (rx_data_i),
      .rd_en_i   (pop),
      .rd_data_o (m_data),
      .count_o   (count),
      .full_o    (full),
      .empty_o   (empty)
   );

   assign m_valid = ~empty;

   // Clear first, then a coincident overrun sets: set wins and the count restarts at 1.
   always_comb begin
      overrun_d = overrun_q;
      ovr_cnt_d = ovr_cnt_q;
      if (ovr_clr) begin
         overrun_d = 1'b0;
         ovr_cnt_d = '0;
      end
      if (ovr_ev) begin
         overrun_d = 1'b1;
         ovr_cnt_d = sat_inc(ovr_cnt_d);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         bits_ok_q <= 1'b1;
         overrun_q <= 1'b0;
         ovr_cnt_q <= '0;
      end else begin
         bits_ok_q <= rx_bits_ok_i;
         overrun_q <= overrun_d;
         ovr_cnt_q <= ovr_cnt_d;
      end
   end

   assign overrun = overrun_q;
   assign ovr_cnt = ovr_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

   logic       sys_clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data_i = '0;
   logic       rx_bits_ok_i = 1'b1;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic [4:0] count;
   logic       full;
   logic       empty;
   logic       overrun;
   logic [7:0] ovr_cnt;
   logic       ovr_clr = 1'b0;

   uart_rx_fifo dut (
      .sys_clk      (sys_clk),
      .rst          (rst),
      .rx_data_i    (rx_data_i),
      .rx_bits_ok_i (rx_bits_ok_i),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .overrun      (overrun),
      .ovr_cnt      (ovr_cnt),
      .ovr_clr      (ovr_clr)
   );

   always #5 sys_clk = ~sys_clk;

   // Reference model: a byte queue plus overrun bookkeeping.
   logic [7:0] mq[$];
   bit         m_prev_bok = 1'b1;
   bit         m_ovr = 1'b0;
   int         m_cnt = 0;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_all();
      chk("count",   32'(count),   32'(mq.size()));
      chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
      chk("m_data",  32'(m_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
      chk("full",    32'(full),    32'(mq.size() == 16));
      chk("empty",   32'(empty),   32'(mq.size() == 0));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("ovr_cnt", 32'(ovr_cnt), 32'(m_cnt));
   endtask

   // One clock cycle: drive inputs, take the edge, advance the model, compare.
   task automatic cyc(input bit bok, input logic [7:0] d, input bit rdy, input bit clr, input bit r);
      bit push, pop, ev;
      rst = r; rx_bits_ok_i = bok; rx_data_i = d; m_ready = rdy; ovr_clr = clr;
      @(posedge sys_clk);
      #1;
      if (r) begin
         mq.delete();
         m_prev_bok = 1'b1;
         m_ovr = 1'b0;
         m_cnt = 0;
      end else begin
         push = bok && !m_prev_bok;
         pop  = rdy && (mq.size() != 0);
         m_prev_bok = bok;
         ev = 1'b0;
         if (pop) void'(mq.pop_front());
         if (push) begin
            if (mq.size() < 16) mq.push_back(d);
            else ev = 1'b1;
         end
         if (clr) begin m_ovr = 1'b0; m_cnt = 0; end
         if (ev) begin m_ovr = 1'b1; if (m_cnt < 255) m_cnt++; end
      end
      check_all();
   endtask

   task automatic frame(input logic [7:0] d, input bit rdy);
      cyc(1'b0, d, rdy, 1'b0, 1'b0);
      cyc(1'b1, d, rdy, 1'b0, 1'b0);
   endtask

   initial begin
      // reset
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_m_data", 32'(m_data), 32'd0);

      // 1: idle level high never pushes
      for (int i = 0; i < 100; i++) cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      chk("t1_count", 32'(count), 32'd0);

      // 2: single frame, then one-cycle accept
      frame(8'hA5, 1'b0);
      chk("t2_m_data", 32'(m_data), 32'hA5);
      chk("t2_count", 32'(count), 32'd1);
      cyc(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("t2_empty", 32'(empty), 32'd1);

      // 3: fill, overrun, ordered drain
      for (int i = 0; i < 16; i++) frame(8'(i), 1'b0);
      chk("t3_full", 32'(full), 32'd1);
      chk("t3_count", 32'(count), 32'd16);
      frame(8'hEE, 1'b0);
      chk("t3_overrun", 32'(overrun), 32'd1);
      chk("t3_ovr_cnt", 32'(ovr_cnt), 32'd1);
      for (int i = 0; i < 16; i++) begin
         chk("t3_drain", 32'(m_data), 32'(i));
         cyc(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      chk("t3_empty", 32'(empty), 32'd1);

      // 4: push coinciding with pop while full
      cyc(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) frame(8'(8'h40 + i), 1'b0);
      cyc(1'b0, 8'h77, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
      chk("t4_count", 32'(count), 32'd16);
      chk("t4_overrun", 32'(overrun), 32'd0);
      for (int i = 0; i < 15; i++) cyc(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("t4_last", 32'(m_data), 32'h77);
      cyc(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);

      // 5: random interleaved traffic across several pointer wraps
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);

      // 6: clear coinciding with overrun, then reset with data buffered
      while (mq.size() != 0) cyc(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 18; i++) frame(8'(8'h80 + i), 1'b0);
      chk("t6_ovr_cnt_pre", 32'(ovr_cnt), 32'd2);
      cyc(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
      chk("t6_overrun", 32'(overrun), 32'd1);
      chk("t6_ovr_cnt", 32'(ovr_cnt), 32'd1);
      for (int i = 0; i < 11; i++) cyc(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("t6_count5", 32'(count), 32'd5);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("t6_rst_empty", 32'(empty), 32'd1);
      chk("t6_rst_count", 32'(count), 32'd0);
      chk("t6_rst_overrun", 32'(overrun), 32'd0);
      frame(8'h3C, 1'b0);
      chk("t6_post_rst", 32'(m_data), 32'h3C);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
